// File: rtl/note_sequencer.sv
// Note table sequencer: fetches note words from a synchronous ROM, drives the
// duration counter load/clear and holds pitch/gate for the oscillator.
module note_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int PITCH_WIDTH = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_loop,
  output logic [ADDR_WIDTH-1:0]    o_rom_addr,
  output logic                     o_rom_rd,
  input  logic [PITCH_WIDTH+4:0]   i_rom_data,
  output logic                     o_load,
  output logic [4:0]               o_duration,
  input  logic                     i_done,
  output logic                     o_counter_clear,
  output logic [PITCH_WIDTH-1:0]   o_pitch,
  output logic                     o_gate,
  output logic                     o_busy,
  output logic                     o_end,
  output logic [2:0]               o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_PLAY   = 3'd4
  } state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   addr, next_addr;
  logic [PITCH_WIDTH+4:0]  note;
  logic [PITCH_WIDTH-1:0]  note_pitch;
  logic                    note_is_end;
  logic                    note_is_rest;
  logic                    stop_hit;
  logic                    end_restart;

  assign note_pitch   = note[PITCH_WIDTH+4:5];
  assign note_is_end  = &note_pitch;
  assign note_is_rest = (note_pitch == '0);
  assign stop_hit     = i_stop && (state != S_IDLE);
  // Restarting from address 0 is refused so an empty table cannot spin.
  assign end_restart  = i_loop && (addr != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      addr  <= '0;
    end else begin
      state <= next_state;
      addr  <= next_addr;
    end
  end

  always_comb begin
    next_state = state;
    next_addr  = addr;
    case (state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          next_state = S_FETCH;
          next_addr  = '0;
        end
      end
      S_FETCH:  next_state = S_WAIT;
      S_WAIT:   next_state = S_DECODE;
      S_DECODE: begin
        if (!note_is_end) begin
          next_state = S_PLAY;
        end else if (end_restart) begin
          next_state = S_FETCH;
          next_addr  = '0;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_PLAY: begin
        if (i_done) begin
          next_state = S_FETCH;
          next_addr  = addr + ADDR_WIDTH'(1);
        end
      end
      default: next_state = S_IDLE;
    endcase
    if (stop_hit) begin
      next_state = S_IDLE;
      next_addr  = addr;
    end
  end

  // ROM read: o_rom_rd is a one-cycle request with o_rom_addr; i_rom_data is
  // valid on the following cycle (WAIT) with no backpressure in either direction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      note            <= '0;
      o_pitch         <= '0;
      o_gate          <= 1'b0;
      o_counter_clear <= 1'b0;
    end else begin
      o_counter_clear <= stop_hit;
      if (state == S_WAIT) begin
        note <= i_rom_data;
      end
      if (stop_hit) begin
        o_gate <= 1'b0;
      end else if (state == S_DECODE) begin
        if (!note_is_end) begin
          o_pitch <= note_pitch;
          o_gate  <= !note_is_rest;
        end else if (!end_restart) begin
          o_gate <= 1'b0;
        end
      end
    end
  end

  assign o_rom_rd   = (state == S_FETCH);
  assign o_rom_addr = addr;
  assign o_load     = (state == S_DECODE) && !note_is_end;
  assign o_duration = note[4:0];
  assign o_end      = (state == S_DECODE) && note_is_end;
  assign o_busy     = (state != S_IDLE);
  assign o_state    = state;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: ROM and duration-counter models, a scoreboard of
// expected {duration, pitch, gate} per load, table vectors and corner sequences.
module tb_note_sequencer;
  localparam int AW = 8;
  localparam int PW = 6;
  localparam int RW = PW + 5;
  localparam int SW = 5 + PW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [RW-1:0] rom_data = '0;
  logic          load;
  logic [4:0]    duration;
  logic          done;
  logic          gen_done = 1'b0;
  logic          man_done = 1'b0;
  logic          counter_clear;
  logic [PW-1:0] pitch;
  logic          gate;
  logic          busy;
  logic          end_pulse;
  logic [2:0]    state_dbg;

  assign done = gen_done | man_done;

  note_sequencer #(.ADDR_WIDTH(AW), .PITCH_WIDTH(PW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_loop(loop),
    .o_rom_addr(rom_addr), .o_rom_rd(rom_rd), .i_rom_data(rom_data),
    .o_load(load), .o_duration(duration), .i_done(done),
    .o_counter_clear(counter_clear), .o_pitch(pitch), .o_gate(gate),
    .o_busy(busy), .o_end(end_pulse), .o_state(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous ROM model
  logic [RW-1:0] mem [256];
  always @(posedge clk) if (rom_rd) rom_data <= mem[rom_addr];

  typedef struct {
    logic [PW-1:0] pitch;
    logic [4:0]    dur;
    logic          exp_gate;
  } vec_t;
  vec_t vecs [7];

  int checks = 0;
  int failures = 0;
  logic [SW-1:0] exp_q[$];
  int end_count = 0;
  int rd_count = 0;
  bit auto_done = 1'b1;
  bit pending = 1'b0;
  bit active = 1'b0;
  logic [4:0] pend_dur = '0;
  int cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) mem[i] = {{PW{1'b1}}, 5'd0};
  endtask

  task automatic load_rom1();
    clear_rom();
    mem[0] = {6'd5, 5'd2};
    mem[1] = {6'd9, 5'd0};
  endtask

  task automatic push_note(input logic [4:0] d, input logic [PW-1:0] p, input logic g);
    exp_q.push_back({d, p, g});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int i;
    i = 0;
    while (busy && i < max) begin
      step();
      i++;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_gate(input string name, input int max);
    int i;
    i = 0;
    while (!gate && i < max) begin
      step();
      i++;
    end
    check({name, "_gate"}, gate, 1);
  endtask

  // scoreboard pop/compare and duration-counter model
  always @(negedge clk) begin
    gen_done = 1'b0;
    if (!rst_n) begin
      pending = 1'b0;
      active  = 1'b0;
    end else begin
      if (pending) begin
        pending = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_load actual_dur=%0d pitch=%0d expected=none", pend_dur, pitch);
        end else begin
          check("note", {pend_dur, pitch, gate}, exp_q.pop_front());
        end
      end
      if (end_pulse) end_count++;
      if (rom_rd) rd_count++;
      if (active) begin
        if (cnt == 0) begin
          gen_done = 1'b1;
          active = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (load) begin
        pending  = 1'b1;
        pend_dur = duration;
        cnt      = int'(duration);
        active   = auto_done;
      end
      if (!busy) active = 1'b0;
    end
  end

  initial begin
    int base;
    int seen;
    vecs[0] = '{pitch: 6'd5,  dur: 5'd2, exp_gate: 1'b1};
    vecs[1] = '{pitch: 6'd9,  dur: 5'd0, exp_gate: 1'b1};
    vecs[2] = '{pitch: 6'd0,  dur: 5'd3, exp_gate: 1'b0};
    vecs[3] = '{pitch: 6'd1,  dur: 5'd1, exp_gate: 1'b1};
    vecs[4] = '{pitch: 6'd62, dur: 5'd4, exp_gate: 1'b1};
    vecs[5] = '{pitch: 6'd0,  dur: 5'd0, exp_gate: 1'b0};
    vecs[6] = '{pitch: 6'd33, dur: 5'd31, exp_gate: 1'b1};
    clear_rom();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd", rom_rd, 0);
    check("rst_load", load, 0);
    check("rst_end", end_pulse, 0);
    check("rst_clear", counter_clear, 0);
    check("rst_gate", gate, 0);
    check("rst_pitch", pitch, 0);
    check("rst_addr", rom_addr, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_busy", busy, 0);

    // basic sequence with exact start latency
    load_rom1();
    loop = 1'b0;
    base = end_count;
    push_note(5'd2, 6'd5, 1'b1);
    push_note(5'd0, 6'd9, 1'b1);
    pulse_start();
    check("c1_rd", rom_rd, 1);
    check("c1_state", state_dbg, 1);
    check("c1_addr", rom_addr, 0);
    step();
    check("c2_rd", rom_rd, 0);
    check("c2_state", state_dbg, 2);
    step();
    check("c3_load", load, 1);
    check("c3_dur", duration, 2);
    check("c3_gate", gate, 0);
    step();
    check("c4_load", load, 0);
    check("c4_pitch", pitch, 5);
    check("c4_gate", gate, 1);
    wait_idle("basic", 200);
    check("basic_ends", end_count - base, 1);
    check("basic_gate", gate, 0);
    check("basic_pitch", pitch, 9);
    check("basic_q", exp_q.size(), 0);

    // looping: three passes, loop dropped after the second end
    load_rom1();
    loop = 1'b1;
    base = end_count;
    for (int k = 0; k < 3; k++) begin
      push_note(5'd2, 6'd5, 1'b1);
      push_note(5'd0, 6'd9, 1'b1);
    end
    pulse_start();
    seen = 0;
    for (int i = 0; i < 400 && seen < 2; i++) begin
      step();
      if (end_pulse) seen++;
    end
    check("loop_seen", seen, 2);
    step();
    check("loop_rd", rom_rd, 1);
    check("loop_addr", rom_addr, 0);
    loop = 1'b0;
    wait_idle("loop", 300);
    check("loop_ends", end_count - base, 3);
    check("loop_q", exp_q.size(), 0);

    // empty table with loop set
    clear_rom();
    loop = 1'b1;
    base = end_count;
    pulse_start();
    wait_idle("empty", 20);
    check("empty_ends", end_count - base, 1);
    base = rd_count;
    repeat (4) step();
    check("empty_no_rd", rd_count - base, 0);
    loop = 1'b0;

    // table-driven vectors, including rests and max duration
    clear_rom();
    for (int i = 0; i < 7; i++) begin
      mem[i] = {vecs[i].pitch, vecs[i].dur};
      push_note(vecs[i].dur, vecs[i].pitch, vecs[i].exp_gate);
    end
    pulse_start();
    wait_idle("table", 600);
    check("table_q", exp_q.size(), 0);
    check("table_gate", gate, 0);

    // start while busy, then stop and done together
    auto_done = 1'b0;
    load_rom1();
    push_note(5'd2, 6'd5, 1'b1);
    pulse_start();
    wait_gate("stop", 20);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_start_state", state_dbg, 4);
    check("busy_start_rd", rom_rd, 0);
    stop = 1'b1;
    man_done = 1'b1;
    step();
    stop = 1'b0;
    man_done = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_gate", gate, 0);
    check("stop_clear", counter_clear, 1);
    check("stop_pitch", pitch, 5);
    check("stop_rd", rom_rd, 0);
    step();
    check("stop_clear_end", counter_clear, 0);
    base = rd_count;
    repeat (3) step();
    check("stop_no_rd", rd_count - base, 0);
    auto_done = 1'b1;

    // stop beats start in IDLE
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check("idle_stop_busy", busy, 0);
    check("idle_stop_clear", counter_clear, 0);
    step();
    check("idle_stop_rd", rom_rd, 0);

    // address wrap from 255 to 0 keeps playing
    clear_rom();
    for (int i = 0; i < 256; i++) begin
      mem[i] = {6'((i % 62) + 1), 5'd0};
      push_note(5'd0, 6'((i % 62) + 1), 1'b1);
    end
    push_note(5'd0, 6'd1, 1'b1);
    base = end_count;
    pulse_start();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) step();
    check("wrap_q", exp_q.size(), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("wrap_busy", busy, 0);
    check("wrap_no_end", end_count - base, 0);
    step();
    exp_q.delete();

    // asynchronous reset in the middle of a note
    load_rom1();
    push_note(5'd2, 6'd5, 1'b1);
    pulse_start();
    wait_gate("arst", 20);
    step();
    check("arst_q", exp_q.size(), 0);
    base = end_count;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_gate", gate, 0);
    check("arst_pitch", pitch, 0);
    check("arst_state", state_dbg, 0);
    check("arst_load", load, 0);
    check("arst_clear", counter_clear, 0);
    check("arst_addr", rom_addr, 0);
    step();
    check("arst_no_end", end_count - base, 0);
    rst_n = 1'b1;
    step();
    check("arst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
